// File: rtl/vga_timing_ctrl.sv
// Raster timing generator for the VGA output path: free-running h/v counters,
// stage-0 decodes, and a two-stage pipeline aligning sync, blank and RGB.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    output logic [9:0] oVGA_X,
    output logic [9:0] oVGA_Y,
    input  logic [9:0] iRed,
    input  logic [9:0] iGreen,
    input  logic [9:0] iBlue,
    output logic [9:0] oVGA_R,
    output logic [9:0] oVGA_G,
    output logic [9:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_N,
    output logic       oFrameStart
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Thresholds pre-sized to the 10-bit counter width.
    localparam logic [9:0] LP_H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] LP_V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] LP_H_ACT       = 10'(H_ACTIVE);
    localparam logic [9:0] LP_V_ACT       = 10'(V_ACTIVE);
    localparam logic [9:0] LP_HS_START    = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] LP_VS_START    = 10'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] LP_HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] LP_VS_END     = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_active0;
    logic       w_hs0;
    logic       w_vs0;
    logic       w_fs0;

    logic       r_active1;
    logic       r_hs1;
    logic       r_vs1;
    logic       r_fs1;

    logic       r_blank_n2;
    logic       r_hs2;
    logic       r_vs2;
    logic       r_fs2;
    logic [9:0] r_red2;
    logic [9:0] r_green2;
    logic [9:0] r_blue2;

    // Stage 0: raster counters
    assign w_h_last = (r_h_cnt == LP_H_LAST);
    assign w_v_last = (r_v_cnt == LP_V_LAST);

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Stage 0 decodes
    always_comb begin
        w_active0 = (r_h_cnt < LP_H_ACT) && (r_v_cnt < LP_V_ACT);
        w_hs0     = !((r_h_cnt >= LP_HS_START) && ({1'b0, r_h_cnt} < LP_HS_END));
        w_vs0     = !((r_v_cnt >= LP_VS_START) && ({1'b0, r_v_cnt} < LP_VS_END));
        w_fs0     = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    // Stage 1: decodes wait here while the pattern generator registers RGB
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_active1 <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_fs1     <= 1'b0;
        end else begin
            r_active1 <= w_active0;
            r_hs1     <= w_hs0;
            r_vs1     <= w_vs0;
            r_fs1     <= w_fs0;
        end
    end

    // Stage 2: aligned outputs
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_blank_n2 <= 1'b0;
            r_hs2      <= 1'b1;
            r_vs2      <= 1'b1;
            r_fs2      <= 1'b0;
            r_red2     <= '0;
            r_green2   <= '0;
            r_blue2    <= '0;
        end else begin
            r_blank_n2 <= r_active1;
            r_hs2      <= r_hs1;
            r_vs2      <= r_vs1;
            r_fs2      <= r_fs1;
            r_red2     <= r_active1 ? iRed   : '0;
            r_green2   <= r_active1 ? iGreen : '0;
            r_blue2    <= r_active1 ? iBlue  : '0;
        end
    end

    assign oVGA_X       = r_h_cnt;
    assign oVGA_Y       = r_v_cnt;
    assign oVGA_R       = r_red2;
    assign oVGA_G       = r_green2;
    assign oVGA_B       = r_blue2;
    assign oVGA_HS      = r_hs2;
    assign oVGA_VS      = r_vs2;
    assign oVGA_BLANK_N = r_blank_n2;
    assign oFrameStart  = r_fs2;

endmodule
